// File: rtl/riscv_pkg.sv
// riscv_pkg: shared front-end definitions.
// Provides the default architectural widths and the fetch entry record
// {pc, instr}. The fetch queue and the decode and rename stages all use it.
package riscv_pkg;

    localparam int PC_SIZE    = 32;
    localparam int INSTR_SIZE = 32;
    localparam int NUM_A_REGS = 32;
    localparam int NUM_P_REGS = 64;

    typedef struct packed {
        logic [PC_SIZE-1:0]    pc;
        logic [INSTR_SIZE-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// fq_storage: a DEPTH-entry {pc, instr} register array with two write ports
// and two read ports.
// Ports:
//   clk_i                      clock
//   wr0_en_i / wr1_en_i        write enables for index wr_idx_i and wr_idx_i+1
//   wr_idx_i                   base write index (tail)
//   wr0_* / wr1_*              write data for the two consecutive indices
//   rd_idx_i                   base read index (head)
//   rd0_* / rd1_*              read data at rd_idx_i and rd_idx_i+1
// The second index of each pair wraps modulo DEPTH, so a pair can straddle
// index DEPTH-1 and index 0. The storage itself is not reset.
module fq_storage #(
    parameter  int DEPTH = 8,
    parameter  int PC_W  = 32,
    parameter  int IN_W  = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr0_en_i,
    input  logic             wr1_en_i,
    input  logic [PTR_W-1:0] wr_idx_i,
    input  logic [PC_W-1:0]  wr0_pc_i,
    input  logic [IN_W-1:0]  wr0_instr_i,
    input  logic [PC_W-1:0]  wr1_pc_i,
    input  logic [IN_W-1:0]  wr1_instr_i,
    input  logic [PTR_W-1:0] rd_idx_i,
    output logic [PC_W-1:0]  rd0_pc_o,
    output logic [IN_W-1:0]  rd0_instr_o,
    output logic [PC_W-1:0]  rd1_pc_o,
    output logic [IN_W-1:0]  rd1_instr_o
);

    logic [PC_W-1:0]  pc_mem    [DEPTH];
    logic [IN_W-1:0]  instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_idx1;
    logic [PTR_W-1:0] rd_idx1;

    // DEPTH is a power of two, so natural overflow gives modulo DEPTH.
    assign wr_idx1 = wr_idx_i + PTR_W'(1);
    assign rd_idx1 = rd_idx_i + PTR_W'(1);

    always_ff @(posedge clk_i) begin
        if (wr0_en_i) begin
            pc_mem[wr_idx_i]    <= wr0_pc_i;
            instr_mem[wr_idx_i] <= wr0_instr_i;
        end
        if (wr1_en_i) begin
            pc_mem[wr_idx1]    <= wr1_pc_i;
            instr_mem[wr_idx1] <= wr1_instr_i;
        end
    end

    assign rd0_pc_o    = pc_mem[rd_idx_i];
    assign rd0_instr_o = instr_mem[rd_idx_i];
    assign rd1_pc_o    = pc_mem[rd_idx1];
    assign rd1_instr_o = instr_mem[rd_idx1];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: a 2-wide in-order instruction buffer between fetch and decode.
// Ports:
//   clk_i, rst_i                clock, asynchronous active-high reset
//   flush_i                     drop all entries and clear the done state
//   enq{0,1}_{valid,pc,instr}_i up to two fetched entries per cycle
//   done_i                      fetch has reached the end of the program
//   enq_ready_o                 room for two entries (from registered count)
//   deq{0,1}_{valid,pc,instr}_o show-ahead head / head+1 (data 0 when invalid)
//   deq_take_i                  entries consumed by decode (0..3, clamped)
//   count_o                     occupancy
//   drained_o                   done seen and queue empty
module fetch_queue #(
    parameter  int PC_SIZE    = riscv_pkg::PC_SIZE,
    parameter  int INSTR_SIZE = riscv_pkg::INSTR_SIZE,
    parameter  int DEPTH      = 8,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  enq0_valid_i,
    input  logic                  enq1_valid_i,
    input  logic [PC_SIZE-1:0]    enq0_pc_i,
    input  logic [PC_SIZE-1:0]    enq1_pc_i,
    input  logic [INSTR_SIZE-1:0] enq0_instr_i,
    input  logic [INSTR_SIZE-1:0] enq1_instr_i,
    input  logic                  done_i,
    output logic                  enq_ready_o,
    output logic                  deq0_valid_o,
    output logic                  deq1_valid_o,
    output logic [PC_SIZE-1:0]    deq0_pc_o,
    output logic [PC_SIZE-1:0]    deq1_pc_o,
    output logic [INSTR_SIZE-1:0] deq0_instr_o,
    output logic [INSTR_SIZE-1:0] deq1_instr_o,
    input  logic [1:0]            deq_take_i,
    output logic [PTR_W:0]        count_o,
    output logic                  drained_o
);

    localparam int CW = PTR_W + 1;

    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  done_q, done_d;
    logic                  enq_ok;
    logic [1:0]            enq_n, take_c, deq_n;
    logic [PC_SIZE-1:0]    wa_pc, rd0_pc, rd1_pc;
    logic [INSTR_SIZE-1:0] wa_instr, rd0_instr, rd1_instr;

    // Depends only on the registered count; a same-cycle dequeue does not
    // make room, which keeps deq_take_i off the ready path.
    assign enq_ready_o = (count_q <= CW'(DEPTH - 2));
    assign enq_ok      = enq_ready_o & ~flush_i;
    assign enq_n       = enq_ok ? ({1'b0, enq0_valid_i} + {1'b0, enq1_valid_i}) : 2'd0;

    // Entries are packed at tail: a lone slot-1 entry goes to tail itself.
    assign wa_pc    = enq0_valid_i ? enq0_pc_i    : enq1_pc_i;
    assign wa_instr = enq0_valid_i ? enq0_instr_i : enq1_instr_i;

    // Decode may ask for 3 or for more than is present; clamp to occupancy.
    assign take_c = (deq_take_i == 2'd3) ? 2'd2 : deq_take_i;
    assign deq_n  = (CW'(take_c) > count_q) ? count_q[1:0] : take_c;

    always_comb begin
        head_d  = head_q + PTR_W'(deq_n);
        tail_d  = tail_q + PTR_W'(enq_n);
        count_d = count_q + CW'(enq_n) - CW'(deq_n);
        done_d  = done_q | done_i;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .PC_W  (PC_SIZE),
        .IN_W  (INSTR_SIZE)
    ) u_storage (
        .clk_i       (clk_i),
        .wr0_en_i    (enq_n != 2'd0),
        .wr1_en_i    (enq_n == 2'd2),
        .wr_idx_i    (tail_q),
        .wr0_pc_i    (wa_pc),
        .wr0_instr_i (wa_instr),
        .wr1_pc_i    (enq1_pc_i),
        .wr1_instr_i (enq1_instr_i),
        .rd_idx_i    (head_q),
        .rd0_pc_o    (rd0_pc),
        .rd0_instr_o (rd0_instr),
        .rd1_pc_o    (rd1_pc),
        .rd1_instr_o (rd1_instr)
    );

    assign deq0_valid_o = (count_q != '0);
    assign deq1_valid_o = (count_q >= CW'(2));
    assign deq0_pc_o    = deq0_valid_o ? rd0_pc    : '0;
    assign deq0_instr_o = deq0_valid_o ? rd0_instr : '0;
    assign deq1_pc_o    = deq1_valid_o ? rd1_pc    : '0;
    assign deq1_instr_o = deq1_valid_o ? rd1_instr : '0;

    assign count_o   = count_q;
    assign drained_o = done_q & (count_q == '0);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam logic [31:0] K = 32'hA5A5A5A5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk_i, rst_i, flush_i, done_i;
    logic        enq0_valid_i, enq1_valid_i;
    logic [31:0] enq0_pc_i, enq1_pc_i, enq0_instr_i, enq1_instr_i;
    logic        enq_ready_o, deq0_valid_o, deq1_valid_o, drained_o;
    logic [31:0] deq0_pc_o, deq1_pc_o, deq0_instr_o, deq1_instr_o;
    logic [1:0]  deq_take_i;
    logic [3:0]  count_o;

    int   checks = 0;
    int   fails  = 0;
    ent_t sb[$];
    bit   mdone;

    fetch_queue #(.PC_SIZE(32), .INSTR_SIZE(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .enq0_valid_i(enq0_valid_i), .enq1_valid_i(enq1_valid_i),
        .enq0_pc_i(enq0_pc_i), .enq1_pc_i(enq1_pc_i),
        .enq0_instr_i(enq0_instr_i), .enq1_instr_i(enq1_instr_i),
        .done_i(done_i), .enq_ready_o(enq_ready_o),
        .deq0_valid_o(deq0_valid_o), .deq1_valid_o(deq1_valid_o),
        .deq0_pc_o(deq0_pc_o), .deq1_pc_o(deq1_pc_o),
        .deq0_instr_o(deq0_instr_o), .deq1_instr_o(deq1_instr_o),
        .deq_take_i(deq_take_i), .count_o(count_o), .drained_o(drained_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Occupancy must never exceed DEPTH.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            checks++;
            if (count_o > DEPTH) begin
                fails++;
                $display("FAIL invariant: count_o=%0d exceeds %0d", count_o, DEPTH);
            end
        end
    end

    function automatic logic [31:0] e_pc(int i);
        if (i < sb.size()) return sb[i].pc;
        return 32'h0;
    endfunction

    function automatic logic [31:0] e_in(int i);
        if (i < sb.size()) return sb[i].instr;
        return 32'h0;
    endfunction

    // Drives one cycle of stimulus and advances the scoreboard the way the
    // queue should: pops honoured takes, pushes accepted entries.
    task automatic drive(input bit v0, input bit v1, input logic [31:0] p0,
                         input logic [31:0] p1, input logic [1:0] take,
                         input bit dn, input bit fl);
        int n;
        bit rdy;
        ent_t e;
        enq0_valid_i = v0; enq1_valid_i = v1;
        enq0_pc_i = p0; enq0_instr_i = p0 ^ K;
        enq1_pc_i = p1; enq1_instr_i = p1 ^ K;
        deq_take_i = take; done_i = dn; flush_i = fl;
        rdy = (DEPTH - sb.size()) >= 2;
        if (fl) begin
            sb.delete();
            mdone = 1'b0;
        end else begin
            n = (take == 2'd3) ? 2 : int'(take);
            if (n > sb.size()) n = sb.size();
            repeat (n) void'(sb.pop_front());
            if (rdy) begin
                if (v0) begin e.pc = p0; e.instr = p0 ^ K; sb.push_back(e); end
                if (v1) begin e.pc = p1; e.instr = p1 ^ K; sb.push_back(e); end
            end
            if (dn) mdone = 1'b1;
        end
        @(posedge clk_i);
        #1;
        enq0_valid_i = 0; enq1_valid_i = 0; deq_take_i = 0; done_i = 0; flush_i = 0;
    endtask

    task automatic test_reset();
        drive(1, 1, 32'h300, 32'h304, 0, 1, 0);
        checks++;
        if (count_o !== 4'd2) begin fails++; $display("FAIL reset_pre_count: got %0d want 2", count_o); end
        #3 rst_i = 1'b1;
        #1;
        checks++;
        if (count_o !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count_o); end
        checks++;
        if ({deq0_valid_o, deq1_valid_o, drained_o} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got %b want 000", {deq0_valid_o, deq1_valid_o, drained_o});
        end
        checks++;
        if ({deq0_pc_o, deq1_pc_o, deq0_instr_o, deq1_instr_o} !== 128'h0) begin
            fails++; $display("FAIL reset_data: got %h %h want 0", deq0_pc_o, deq1_pc_o);
        end
        checks++;
        if (enq_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", enq_ready_o); end
        sb.delete();
        mdone = 1'b0;
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) drive(1, 1, 32'(8 * i), 32'(8 * i + 4), 0, 0, 0);
        checks++;
        if (count_o !== 4'd8) begin fails++; $display("FAIL fill_count: got %0d want 8", count_o); end
        checks++;
        if (enq_ready_o !== 1'b0) begin fails++; $display("FAIL fill_ready: got %b want 0", enq_ready_o); end
        drive(1, 1, 32'h40, 32'h44, 0, 0, 0);
        checks++;
        if (count_o !== 4'd8) begin fails++; $display("FAIL fill_drop_count: got %0d want 8", count_o); end
        checks++;
        if (deq0_pc_o !== 32'h0 || deq1_pc_o !== 32'h4) begin
            fails++; $display("FAIL fill_head: got %h/%h want 0/4", deq0_pc_o, deq1_pc_o);
        end
        checks++;
        if (deq0_instr_o !== e_in(0) || deq1_instr_o !== e_in(1)) begin
            fails++; $display("FAIL fill_instr: got %h/%h want %h/%h", deq0_instr_o, deq1_instr_o, e_in(0), e_in(1));
        end
    endtask

    task automatic test_drain_wrap();
        drive(0, 0, 0, 0, 2, 0, 0);
        checks++;
        if (count_o !== 4'd6) begin fails++; $display("FAIL wrap_count6: got %0d want 6", count_o); end
        checks++;
        if (deq0_pc_o !== 32'h8 || deq1_pc_o !== 32'hC) begin
            fails++; $display("FAIL wrap_head: got %h/%h want 8/c", deq0_pc_o, deq1_pc_o);
        end
        drive(1, 1, 32'd32, 32'd36, 0, 0, 0);
        checks++;
        if (count_o !== 4'd8) begin fails++; $display("FAIL wrap_count8: got %0d want 8", count_o); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (deq0_pc_o !== 32'(8 + 8 * k) || deq1_pc_o !== 32'(12 + 8 * k) ||
                deq0_pc_o !== e_pc(0) || deq1_instr_o !== e_in(1)) begin
                fails++; $display("FAIL wrap_order%0d: got %h/%h want %h/%h", k, deq0_pc_o, deq1_pc_o, 8 + 8 * k, 12 + 8 * k);
            end
            drive(0, 0, 0, 0, 2, 0, 0);
        end
        checks++;
        if (count_o !== 4'd0 || deq0_valid_o !== 1'b0) begin
            fails++; $display("FAIL wrap_empty: got count %0d valid %b want 0/0", count_o, deq0_valid_o);
        end
    endtask

    task automatic test_simultaneous();
        drive(1, 1, 32'h200, 32'h204, 0, 0, 0);
        drive(1, 0, 32'h208, 32'h0, 0, 0, 0);
        checks++;
        if (count_o !== 4'd3 || deq0_pc_o !== 32'h200) begin
            fails++; $display("FAIL sim_pre: got count %0d pc %h want 3/200", count_o, deq0_pc_o);
        end
        drive(1, 1, 32'd40, 32'd44, 1, 0, 0);
        checks++;
        if (count_o !== 4'd4 || deq0_pc_o !== 32'h204 || deq1_pc_o !== 32'h208) begin
            fails++; $display("FAIL sim_both: got count %0d pc %h/%h want 4/204/208", count_o, deq0_pc_o, deq1_pc_o);
        end
        drive(0, 0, 0, 0, 3, 0, 0);
        checks++;
        if (count_o !== 4'd2 || deq0_pc_o !== 32'd40 || deq1_pc_o !== 32'd44) begin
            fails++; $display("FAIL sim_take3: got count %0d pc %h/%h want 2/28/2c", count_o, deq0_pc_o, deq1_pc_o);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 3, 0, 0);
        checks++;
        if (count_o !== 4'd0 || deq0_valid_o !== 1'b0 || deq0_pc_o !== 32'h0) begin
            fails++; $display("FAIL sim_clamp: got count %0d valid %b want 0/0", count_o, deq0_valid_o);
        end
    endtask

    task automatic test_single_slot();
        drive(0, 1, 32'h0, 32'h100, 0, 0, 0);
        checks++;
        if (count_o !== 4'd1 || deq0_pc_o !== 32'h100 || deq0_instr_o !== (32'h100 ^ K)) begin
            fails++; $display("FAIL single_head: got count %0d pc %h want 1/100", count_o, deq0_pc_o);
        end
        checks++;
        if (deq1_valid_o !== 1'b0 || deq1_pc_o !== 32'h0 || deq1_instr_o !== 32'h0) begin
            fails++; $display("FAIL single_second: got valid %b pc %h want 0/0", deq1_valid_o, deq1_pc_o);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_flush_done();
        drive(1, 1, 32'h500, 32'h504, 0, 0, 0);
        drive(1, 1, 32'h508, 32'h50C, 0, 0, 0);
        drive(1, 0, 32'h510, 32'h0, 0, 1, 0);
        checks++;
        if (count_o !== 4'd5 || drained_o !== 1'b0) begin
            fails++; $display("FAIL done_busy: got count %0d drained %b want 5/0", count_o, drained_o);
        end
        drive(0, 0, 0, 0, 2, 0, 0);
        drive(0, 0, 0, 0, 2, 0, 0);
        checks++;
        if (count_o !== 4'd1 || drained_o !== 1'b0 || deq0_pc_o !== 32'h510) begin
            fails++; $display("FAIL done_partial: got count %0d drained %b pc %h want 1/0/510", count_o, drained_o, deq0_pc_o);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (drained_o !== 1'b1) begin fails++; $display("FAIL done_drained: got %b want 1", drained_o); end
        drive(1, 1, 32'h600, 32'h604, 2, 0, 1);
        checks++;
        if (count_o !== 4'd0 || drained_o !== 1'b0 || deq0_valid_o !== 1'b0 || enq_ready_o !== 1'b1) begin
            fails++; $display("FAIL flush: got count %0d drained %b valid %b ready %b want 0/0/0/1",
                              count_o, drained_o, deq0_valid_o, enq_ready_o);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (drained_o !== 1'b1 || count_o !== 4'd0) begin
            fails++; $display("FAIL done_again: got drained %b count %0d want 1/0", drained_o, count_o);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc = 32'h1000;
        for (int c = 0; c < 300; c++) begin
            checks++;
            if (count_o !== 4'(sb.size()) || deq0_pc_o !== e_pc(0) || deq1_pc_o !== e_pc(1) ||
                deq0_instr_o !== e_in(0) || deq1_instr_o !== e_in(1) ||
                deq0_valid_o !== (sb.size() >= 1) || deq1_valid_o !== (sb.size() >= 2) ||
                enq_ready_o !== ((DEPTH - sb.size()) >= 2) || drained_o !== (mdone && sb.size() == 0)) begin
                fails++;
                $display("FAIL b2b cycle %0d: got count %0d pc %h/%h rdy %b drn %b want %0d %h/%h",
                         c, count_o, deq0_pc_o, deq1_pc_o, enq_ready_o, drained_o, sb.size(), e_pc(0), e_pc(1));
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pc, pc + 4,
                  2'($urandom_range(0, 3)), ($urandom_range(0, 49) == 0), ($urandom_range(0, 39) == 0));
            pc = pc + 8;
        end
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 0; done_i = 0; deq_take_i = 0;
        enq0_valid_i = 0; enq1_valid_i = 0;
        enq0_pc_i = 0; enq1_pc_i = 0; enq0_instr_i = 0; enq1_instr_i = 0;
        mdone = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        test_reset();
        test_fill();
        test_drain_wrap();
        test_simultaneous();
        test_single_slot();
        test_flush_done();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
